// File: rtl/bk_multiword_add_seq.sv
// Sequential multi-precision add/subtract built on one 32-bit Brent-Kung adder.
// Operand words arrive LS word first; the carry is chained across accepts and
// each sum word is delivered through a single registered valid/ready stage.

// 32-bit combinational Brent-Kung adder (no carry-out port).
module brent_kung_adder (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] out
);

    // Prefix tree over bits 30:0; bit 31 only needs the carry into it.
    always_comb begin : prefix
        logic [30:0] gg;
        logic [30:0] pp;
        logic [31:0] carry;
        gg = in1[30:0] & in2[30:0];
        pp = in1[30:0] ^ in2[30:0];
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 31; i++) begin
                if (((i + 1) % (2 << d)) == 0) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << d))]);
                    pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << d))];
                end
            end
        end
        for (int d = 3; d >= 0; d--) begin
            for (int i = 0; i < 31; i++) begin
                if ((((i + 1) % (2 << d)) == (1 << d)) && (i >= (2 << d))) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << d))]);
                    pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << d))];
                end
            end
        end
        carry = {gg | (pp & {31{cin}}), cin};
        out   = (in1 ^ in2) ^ carry;
    end

endmodule

module bk_multiword_add_seq #(
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err
);

    localparam int unsigned W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

    typedef enum logic {FIRST = 1'b0, MID = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             out_valid_d, out_cout_d, out_last_d, out_err_d;
    logic [W-1:0]     out_sum_d;
    logic [IDX_W-1:0] out_idx_d;

    logic             accept, mode, c0, cw, at_limit, terminal;
    logic [W-1:0]     add_in2, add_out;

    // Single output register: a new word may enter whenever the slot frees.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // First word samples mode/carry-in from the port; later words use the chain.
    assign mode    = (state_q == FIRST) ? in_sub : sub_q;
    assign c0      = (state_q == FIRST) ? (in_sub | in_cin) : carry_q;
    assign add_in2 = in_b ^ {W{mode}};

    brent_kung_adder u_adder (
        .in1 (in_a),
        .in2 (add_in2),
        .cin (c0),
        .out (add_out)
    );

    // Carry out of the word, rebuilt from the MSB of operands and sum.
    assign cw = (in_a[W-1] & add_in2[W-1]) | ((in_a[W-1] ^ add_in2[W-1]) & ~add_out[W-1]);

    assign at_limit = (idx_q == LAST_IDX);
    assign terminal = in_last || at_limit;

    // Next-state and next-output selection.
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        out_valid_d = out_valid && !out_ready;
        out_sum_d   = out_sum;
        out_cout_d  = out_cout;
        out_last_d  = out_last;
        out_idx_d   = out_idx;
        out_err_d   = out_err;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_out;
            out_cout_d  = cw;
            out_last_d  = terminal;
            out_idx_d   = idx_q;
            out_err_d   = at_limit && !in_last;
            carry_d     = cw;
            sub_d       = mode;
            if (terminal) begin
                state_d = FIRST;
                idx_d   = '0;
            end else begin
                state_d = MID;
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FIRST;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            sub_q     <= sub_d;
            idx_q     <= idx_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_cout  <= out_cout_d;
            out_last  <= out_last_d;
            out_idx   <= out_idx_d;
            out_err   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Bench for bk_multiword_add_seq: packet-level arithmetic model plus directed literals.
module tb_bk_multiword_add_seq;

    localparam int unsigned MAXW  = 4;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned PW    = 32 * MAXW;
    localparam int unsigned XW    = PW + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid, in_ready, in_last, in_cin, in_sub;
    logic [31:0]      in_a, in_b;
    logic             out_valid, out_ready, out_cout, out_last, out_err;
    logic [31:0]      out_sum;
    logic [IDX_W-1:0] out_idx;

    bk_multiword_add_seq #(.MAX_WORDS(MAXW), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected contents of the output slot, from whole-packet arithmetic.
    bit          m_valid, m_cout, m_last, m_err, m_first, m_sub, m_c0, last_acc;
    logic [31:0] m_sum;
    int          m_idx_o, m_k;
    logic [PW-1:0] pa, pb;

    task automatic model_reset();
        m_valid = 0; m_sum = '0; m_cout = 0; m_last = 0; m_err = 0; m_idx_o = 0;
        m_first = 1; m_k = 0; m_sub = 0; m_c0 = 0; pa = '0; pb = '0;
    endtask

    // Word k of the packet is slice k of (A + (B or ~B) + c0) over the low k+1 words.
    task automatic model_accept();
        int n;
        logic [XW-1:0] mask, bb, wide;
        if (m_first) begin
            m_sub = in_sub;
            m_c0  = in_sub ? 1'b1 : in_cin;
            pa = '0; pb = '0;
        end
        pa[32*m_k +: 32] = in_a;
        pb[32*m_k +: 32] = in_b;
        n    = 32 * (m_k + 1);
        mask = (XW'(1) << n) - XW'(1);
        bb   = m_sub ? ~{1'b0, pb} : {1'b0, pb};
        wide = ({1'b0, pa} & mask) + (bb & mask) + XW'(m_c0);
        m_sum   = wide[32*m_k +: 32];
        m_cout  = wide[n];
        m_idx_o = m_k;
        m_last  = in_last || (m_k == int'(MAXW) - 1);
        m_err   = (m_k == int'(MAXW) - 1) && !in_last;
        m_valid = 1;
        m_first = m_last;
        m_k     = m_last ? 0 : m_k + 1;
    endtask

    task automatic model_clock();
        last_acc = in_valid && (!m_valid || out_ready);
        if (last_acc) model_accept();
        else if (out_ready) m_valid = 0;
    endtask

    // One clock: advance the model at the edge, return 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clock();
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic last);
        in_valid = 1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_last = last;
        step();
        in_valid = 0;
    endtask

    task automatic lit(input string tag, input logic [31:0] sum, input logic cout,
                       input logic last, input int idx, input logic err);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_sum"},   64'(out_sum),   64'(sum));
        chk({tag, "_cout"},  64'(out_cout),  64'(cout));
        chk({tag, "_last"},  64'(out_last),  64'(last));
        chk({tag, "_idx"},   64'(out_idx),   64'(idx));
        chk({tag, "_err"},   64'(out_err),   64'(err));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 4)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_sum",  64'(out_sum),  64'(m_sum));
            chk("out_cout", 64'(out_cout), 64'(m_cout));
            chk("out_last", 64'(out_last), 64'(m_last));
            chk("out_idx",  64'(out_idx),  64'(m_idx_o));
            chk("out_err",  64'(out_err),  64'(m_err));
        end
    end

    initial begin
        rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_last = 0; in_cin = 0; in_sub = 0;
        out_ready = 1; last_acc = 0;
        model_reset();
        #2;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sum",   64'(out_sum),   64'(0));
        chk("rst_idx",   64'(out_idx),   64'(0));
        chk("rst_ready", 64'(in_ready),  64'(1));
        step(); step();
        rst_n = 1;

        // Single-word add with wrap.
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 1);
        lit("add1", 32'h0, 1, 1, 0, 0);
        step();

        // Three-word add, back-to-back.
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        lit("add3_w0", 32'h0, 1, 0, 0, 0);
        chk("add3_ready0", 64'(in_ready), 64'(1));
        send(32'hFFFF_FFFF, 32'h0, 1, 1, 0);
        lit("add3_w1", 32'h0, 1, 0, 1, 0);
        send(32'h1, 32'h0, 0, 0, 1);
        lit("add3_w2", 32'h2, 0, 1, 2, 0);

        // Subtract: single word, then two words.
        send(32'h5, 32'h7, 0, 1, 1);
        lit("sub1", 32'hFFFF_FFFE, 0, 1, 0, 0);
        send(32'h0, 32'h1, 0, 1, 0);
        lit("sub2_w0", 32'hFFFF_FFFF, 0, 0, 0, 0);
        send(32'h1, 32'h0, 0, 0, 1);
        lit("sub2_w1", 32'h0, 1, 1, 1, 0);

        // Backpressure after word 0.
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        out_ready = 0;
        in_valid = 1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_last = 0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("bp_ready", 64'(in_ready), 64'(0));
            lit("bp_hold", 32'h0, 1, 0, 0, 0);
        end
        out_ready = 1;
        step();
        in_valid = 0;
        lit("bp_w1", 32'h0, 1, 0, 1, 0);
        send(32'h1, 32'h0, 0, 0, 1);
        lit("bp_w2", 32'h2, 0, 1, 2, 0);

        // Truncation at MAXW words; the fifth word starts a new packet.
        for (int k = 0; k < 5; k++) begin
            send(32'hFFFF_FFFF, 32'h0, logic'(k == 4), 0, 0);
            if (k == 3) lit("trunc_w3", 32'hFFFF_FFFF, 0, 1, 3, 1);
            if (k == 4) lit("trunc_w4", 32'h0, 1, 0, 0, 0);
        end
        send(32'h0, 32'h0, 0, 0, 1);

        // Asynchronous reset mid-packet.
        send(32'h1, 32'h2, 1, 0, 0);
        send(32'h3, 32'h4, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_ready", 64'(in_ready), 64'(1));
        model_reset();
        step();
        rst_n = 1;
        send(32'h2, 32'h3, 0, 0, 1);
        lit("post_rst", 32'h5, 0, 1, 0, 0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom % 4) != 0;
                in_a     = pick();
                in_b     = pick();
                in_cin   = 1'($urandom % 2);
                in_sub   = 1'($urandom % 2);
                in_last  = ($urandom % 3) == 0;
            end
            out_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bk_multiword_add_seq.md
Name: bk_multiword_add_seq

Overview:
- Sequential multi-precision add/subtract front-end built around the team's 32-bit combinational Brent-Kung adder (`brent_kung_adder`: in1, in2, cin -> out). One instance only.
- Accepts a stream of 32-bit operand word pairs, least-significant word first, and feeds each pair to the adder with a carry chained across cycles.
- Registers each 32-bit sum word and delivers it downstream with a valid/ready handshake.
- Supports operands of 1..MAX_WORDS words: 32..32*MAX_WORDS bits.

Parameters:
- MAX_WORDS, 16, maximum words per packet. Legal range 2..256.
- IDX_W, 8, width of the word index. Must satisfy 2^IDX_W >= MAX_WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand word pair present.
- in_ready  output  1  block accepts the word this cycle.
- in_a  input  32  operand A word.
- in_b  input  32  operand B word.
- in_last  input  1  this is the most-significant word of the packet.
- in_cin  input  1  carry-in. Sampled only on the first word of a packet.
- in_sub  input  1  1 = A-B, 0 = A+B. Sampled only on the first word of a packet.
- out_valid  output  1  sum word present.
- out_ready  input  1  downstream accepts the sum word.
- out_sum  output  32  sum word.
- out_cout  output  1  carry out of this word (for subtract: 1 = no borrow).
- out_last  output  1  final word of the packet.
- out_idx  output  IDX_W  word index within the packet, 0 = least significant.
- out_err  output  1  packet truncated at MAX_WORDS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: out_valid=0, out_sum=0, out_cout=0, out_last=0, out_idx=0, out_err=0.
  - Internal: carry_q=0, sub_q=0, idx_q=0, state=FIRST.
  - in_ready depends only on out_valid, so it reads 1 during reset.
- Reset asserted mid-packet discards the partial packet. The first word accepted after reset starts a new packet.
- Handshake:
  - in_ready = !out_valid || out_ready. This is a single output register with full throughput: one word per cycle when out_ready=1.
  - Accept event: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable and no internal state changes.
- Adder inputs on an accept:
  - in1 = in_a.
  - in2 = in_b ^ {32{mode}}.
  - cin = c0.
- Selection in state FIRST: mode = in_sub, c0 = in_sub ? 1 : in_cin.
- Selection in state MID: mode = sub_q, c0 = carry_q.
- Word carry-out:
  - cw = (in_a[31] & in2[31]) | ((in_a[31] ^ in2[31]) & ~out[31]).
  - Equivalently, bit 32 of in_a + in2 + c0.
  - Computed locally. The adder core exposes no carry-out port.
- Latency: 1 cycle. The registered outputs update on the edge that accepts the word.
- Registered on each accept:
  - out_sum = adder out.
  - out_cout = cw.
  - out_idx = idx_q.
  - carry_q = cw.
  - sub_q = mode.
- State machine, 2 states, transitions only on accept:
  - FIRST -> MID when the word is not terminal.
  - MID -> MID when the word is not terminal.
  - Any state -> FIRST when terminal. Terminal = in_last || idx_q == MAX_WORDS-1.
  - idx_q increments on each non-terminal accept and clears to 0 on a terminal accept.
- Per-word flags:
  - out_last = terminal.
  - out_err = (idx_q == MAX_WORDS-1) && !in_last.
- After a truncating accept (out_err=1), the next input word is treated as the first word of a new packet. in_sub and in_cin are re-sampled.
- in_cin and in_sub on non-first words are ignored.
- An accept and an output transfer in the same cycle are legal: the output register reloads, and out_valid stays 1.
- No accept combined with an output transfer: out_valid -> 0.
- Wrap-around: out_sum is modulo 2^32 per word. The overflow of the full operand is reported only via out_cout on the out_last word.

Test Plan:
- Single-word add:
  - Stimulus: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, last=1.
  - Response one cycle later: out_sum=0x00000000, out_cout=1, out_last=1, out_idx=0, out_err=0.
- 3-word add, back-to-back, out_ready=1:
  - Stimulus: A words {0xFFFFFFFF, 0xFFFFFFFF, 0x00000001}, B words {0x00000001, 0, 0}.
  - Response: sums {0, 0, 0x00000002}, couts {1, 1, 0}, out_idx 0,1,2, out_last only on idx 2.
  - in_ready stays high throughout.
- Subtract:
  - Single word: a=5, b=7, sub=1, cin=0 (ignored) -> out_sum=0xFFFFFFFE, out_cout=0.
  - Then 2-word: A={0, 1}, B={1, 0}, sub=1 -> sums {0xFFFFFFFF, 0x00000000}, final out_cout=1.
- Backpressure:
  - Stimulus: during a 3-word add, drop out_ready for 3 cycles after word 0 is output.
  - Response: in_ready=0; out_sum, out_cout and out_idx are held. Word 1 is accepted only after out_ready=1.
  - The result sequence is identical to the no-stall run.
- Truncation (MAX_WORDS=4):
  - Stimulus: 5 words of a=0xFFFFFFFF, b=0, none with last; the 5th word has cin=1.
  - Response: word idx 3 has out_last=1, out_err=1.
  - The 5th word outputs out_idx=0, out_sum=0x00000000, out_cout=1, using its own cin.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 asynchronously between clock edges after word 1 of a 3-word packet.
  - Response: out_valid=0 immediately.
  - After release, a single word a=2, b=3, cin=0, last=1 gives out_sum=5, out_idx=0 (no stale carry).
